min_hour_counter: RTL and testbench
===================================

Name: min_hour_counter

Overview:
- Stage directly downstream of the seconds counter; consumes its one-cycle tick_1m pulse.
- Maintains minutes (0-59) and hours (internal 24 h, 0-23), presents hours in 24 h or 12 h display format, and emits a one-cycle tick_1d at midnight rollover.
- Provides a time-set mode driven by user inc inputs. These are debounced upstream but level-held; this block edge-detects them.

Parameters:
- RESET_MIN, 0, minute value loaded on reset; legal range 0-59.
- RESET_HOUR, 0, internal 24 h hour value loaded on reset; legal range 0-23.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Synchronous, active-high, on clock clk.
- tick_1m  input  1  one-cycle pulse from the seconds stage, once per minute.
- mode_12h  input  1  display format select: 0 = 24 h, 1 = 12 h; may change at any time.
- set_en  input  1  time-set mode: 1 freezes timekeeping and enables inc inputs.
- inc_min  input  1  level input; each rising edge while set_en=1 advances minutes by one.
- inc_hour  input  1  level input; each rising edge while set_en=1 advances hours by one.
- minutes  output  6  current minutes, 0-59.
- hours  output  5  display hours: 0-23 in 24 h mode, 1-12 in 12 h mode.
- pm  output  1  1 when internal hour is 12-23, independent of mode_12h.
- tick_1d  output  1  one-cycle pulse on the 23:59 -> 00:00 rollover.

Behaviour:
- State registers:
  - min_r[5:0]
  - hr_r[4:0] (24 h)
  - inc_min_d, inc_hour_d (previous-cycle samples for edge detect)
  - tick_1d register
- Reset (rst=1 at posedge clk):
  - min_r=RESET_MIN, hr_r=RESET_HOUR
  - inc_min_d=0, inc_hour_d=0, tick_1d=0
  - Reset takes priority over all other inputs, including mid set-mode.
- Edge detect:
  - inc_min_d and inc_hour_d sample the inputs every cycle, including when set_en=0.
  - inc_min_rise = inc_min & ~inc_min_d; same form for hour.
  - A level already high when set_en asserts does not count as an edge.
- Run mode (set_en=0, tick_1m=1), counter update:
  - If min_r<59: min_r+1.
  - Else min_r=0 and the hour carries: hr_r+1, or 0 if hr_r=23.
- Run mode, tick_1d:
  - tick_1d=1 for the cycle following the tick_1m that rolls 23:59 to 00:00.
  - It is registered, so it rises in the same cycle minutes/hours show 00:00.
  - It is 0 in all other cycles.
- Run mode with tick_1m=0: state holds, tick_1d=0.
- Set mode (set_en=1):
  - tick_1m is ignored; set has priority over simultaneous tick_1m, and that tick is lost.
  - inc_min_rise: min_r wraps 59->0 with no hour carry.
  - inc_hour_rise: hr_r wraps 23->0.
  - Simultaneous inc_min_rise and inc_hour_rise apply both increments in the same cycle.
  - tick_1d is never asserted in set mode.
- Leaving set mode: counting resumes with the next tick_1m. No other side effect.
- Display (combinational from hr_r, mode_12h):
  - 24 h mode: hours=hr_r.
  - 12 h mode: hr_r=0 -> 12; 1-12 -> hr_r; 13-23 -> hr_r-12.
  - pm = (hr_r>=12).
  - minutes=min_r.
- Latency: counter outputs update one clock after the qualifying tick_1m or edge. mode_12h affects hours/pm in the same cycle.
- Widths: all compares against 6'd59 / 5'd23. Increments are width-matched, with no overflow beyond the wrap values.

Test Plan:
- Reset: rst=1 for 2 cycles with defaults -> minutes=0, hours=0, pm=0, tick_1d=0. Then 60 tick_1m pulses 5 clocks apart -> minutes=0, hours=1, tick_1d never high.
- Midnight: set to 23:59 via inc inputs, clear set_en, one tick_1m -> next cycle minutes=0, hours=0, tick_1d=1 for exactly one cycle. Second tick_1m -> 00:01, tick_1d=0.
- 12 h display: hr_r=0 -> hours=12, pm=0; hr_r=12 -> hours=12, pm=1; hr_r=13 -> hours=1, pm=1; hr_r=23 with mode_12h=0 -> hours=23, pm=1.
- Set mode:
  - Hold inc_min high 10 cycles -> minutes +1 only.
  - 60 inc_min edges from 00 -> minutes=0, hours unchanged.
  - tick_1m during set_en=1 -> no change.
- Simultaneous edges: set_en=1 at 23:59, inc_min and inc_hour rise in the same cycle -> 00:00, tick_1d=0.
- Reset mid-operation: rst asserted while set_en=1 and inc_hour high -> 00:00 next cycle. After rst release with inc_hour still high -> one increment, because inc_hour_d was cleared by reset.

Source files
------------

// File: rtl/min_hour_counter.sv
`default_nettype none
// ============================================================================
// Module   : min_hour_counter
// Brief    : Minutes/hours timekeeping stage with 12/24 h display and set mode.
// Revision : 1.0 - initial release
// ============================================================================
module min_hour_counter #(
  parameter int RESET_MIN  = 0,
  parameter int RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1m,
  input  logic       mode_12h,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       tick_1d
);

  localparam logic [5:0] C_MIN_RST  = 6'(RESET_MIN);
  localparam logic [4:0] C_HOUR_RST = 5'(RESET_HOUR);
  localparam logic [5:0] C_MIN_MAX  = 6'd59;
  localparam logic [4:0] C_HOUR_MAX = 5'd23;

  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       inc_min_prev_q, inc_min_prev_d;
  logic       inc_hour_prev_q, inc_hour_prev_d;
  logic       tick_1d_q, tick_1d_d;
  logic       w_inc_min_rise;
  logic       w_inc_hour_rise;

  assign w_inc_min_rise  = inc_min & ~inc_min_prev_q;
  assign w_inc_hour_rise = inc_hour & ~inc_hour_prev_q;

  always_comb begin
    min_d           = min_q;
    hr_d            = hr_q;
    tick_1d_d       = 1'b0;
    inc_min_prev_d  = inc_min;
    inc_hour_prev_d = inc_hour;
    if (set_en) begin
      // Set mode owns the counters; any coincident tick_1m is dropped.
      if (w_inc_min_rise) begin
        min_d = (min_q == C_MIN_MAX) ? 6'd0 : min_q + 6'd1;
      end
      if (w_inc_hour_rise) begin
        hr_d = (hr_q == C_HOUR_MAX) ? 5'd0 : hr_q + 5'd1;
      end
    end else if (tick_1m) begin
      if (min_q != C_MIN_MAX) begin
        min_d = min_q + 6'd1;
      end else begin
        min_d = 6'd0;
        if (hr_q == C_HOUR_MAX) begin
          hr_d      = 5'd0;
          tick_1d_d = 1'b1;
        end else begin
          hr_d = hr_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q           <= C_MIN_RST;
      hr_q            <= C_HOUR_RST;
      inc_min_prev_q  <= 1'b0;
      inc_hour_prev_q <= 1'b0;
      tick_1d_q       <= 1'b0;
    end else begin
      min_q           <= min_d;
      hr_q            <= hr_d;
      inc_min_prev_q  <= inc_min_prev_d;
      inc_hour_prev_q <= inc_hour_prev_d;
      tick_1d_q       <= tick_1d_d;
    end
  end

  always_comb begin
    hours = hr_q;
    if (mode_12h) begin
      if (hr_q == 5'd0) begin
        hours = 5'd12;
      end else if (hr_q > 5'd12) begin
        hours = hr_q - 5'd12;
      end
    end
  end

  assign pm      = (hr_q >= 5'd12);
  assign minutes = min_q;
  assign tick_1d = tick_1d_q;

endmodule
`default_nettype wire

// File: tb/tb_min_hour_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_min_hour_counter
// Brief    : Scoreboard bench for min_hour_counter against a time-of-day model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_min_hour_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1m = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_en = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       tick_1d;

  min_hour_counter #(.RESET_MIN(0), .RESET_HOUR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1m  (tick_1m),
    .mode_12h (mode_12h),
    .set_en   (set_en),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .minutes  (minutes),
    .hours    (hours),
    .pm       (pm),
    .tick_1d  (tick_1d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn;
    int hr;
    int pm;
    int tk;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: time of day as minutes since midnight.
  int tod    = 0;
  bit m_pmin = 1'b0;
  bit m_phr  = 1'b0;

  task automatic step(input bit r, input bit t, input bit md, input bit s,
                      input bit im, input bit ih);
    exp_t e;
    int   mn;
    int   hr;
    int   disp;
    bit   tk;
    @(negedge clk);
    rst = r; tick_1m = t; mode_12h = md; set_en = s; inc_min = im; inc_hour = ih;
    tk = 1'b0;
    if (r) begin
      tod = 0; m_pmin = 1'b0; m_phr = 1'b0;
    end else begin
      if (s) begin
        mn = tod % 60;
        hr = tod / 60;
        if (im && !m_pmin) mn = (mn + 1) % 60;
        if (ih && !m_phr)  hr = (hr + 1) % 24;
        tod = hr * 60 + mn;
      end else if (t) begin
        tod = (tod + 1) % 1440;
        tk  = (tod == 0);
      end
      m_pmin = im;
      m_phr  = ih;
    end
    hr = tod / 60;
    if (md) begin
      disp = hr % 12;
      if (disp == 0) disp = 12;
    end else begin
      disp = hr;
    end
    e.mn = tod % 60;
    e.hr = disp;
    e.pm = (hr >= 12) ? 1 : 0;
    e.tk = tk ? 1 : 0;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (int'(minutes) != e.mn) begin
          failures++;
          $display("FAIL minutes t=%0t got=%0d exp=%0d", $time, minutes, e.mn);
        end
        checks++;
        if (int'(hours) != e.hr) begin
          failures++;
          $display("FAIL hours t=%0t got=%0d exp=%0d", $time, hours, e.hr);
        end
        checks++;
        if (int'(pm) != e.pm) begin
          failures++;
          $display("FAIL pm t=%0t got=%0d exp=%0d", $time, pm, e.pm);
        end
        checks++;
        if (int'(tick_1d) != e.tk) begin
          failures++;
          $display("FAIL tick_1d t=%0t got=%0d exp=%0d", $time, tick_1d, e.tk);
        end
      end
    end
  end

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, md, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_min(input bit md);
    step(1'b0, 1'b0, md, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, md, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_hour(input bit md);
    step(1'b0, 1'b0, md, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, md, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int m);
    int nh;
    int nm;
    nh = (h - tod / 60 + 24) % 24;
    nm = (m - tod % 60 + 60) % 60;
    for (int i = 0; i < nh; i++) press_hour(1'b0);
    for (int i = 0; i < nm; i++) press_min(1'b0);
  endtask

  initial begin
    bit r, t, md, s, im, ih;
    int budget;

    // Reset, then 60 minute ticks five clocks apart.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
    end

    // Midnight rollover and the minute after it.
    set_time(23, 59);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Every hour shown in both display formats.
    for (int h = 0; h < 24; h++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      press_hour(1'b1);
    end

    // Held inc_min counts once; 60 edges wrap minutes without hour carry.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_time(5, 0);
    for (int i = 0; i < 60; i++) press_min(1'b0);

    // A level already high when set_en asserts is not an edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // tick_1m in set mode is lost, including one coincident with an edge.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous edges at 23:59 give 00:00 with no day tick.
    set_time(23, 59);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in set mode with inc_hour held, then release while still held.
    set_time(7, 30);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, biased to cross hour and day boundaries.
    set_time(23, 40);
    s = 1'b0; im = 1'b0; ih = 1'b0; md = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) md = ~md;
      if ($urandom_range(0, 40) == 0) s = ~s;
      if ($urandom_range(0, 3) == 0) im = ~im;
      if ($urandom_range(0, 5) == 0) ih = ~ih;
      step(r, t, md, s, im, ih);
    end
    idle(2, 1'b0);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
